uart_rx: RTL
============

# uart_rx

Serial receiver for the 8N1 UART link, paired with the existing transmitter: same framing (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) and the same shared 16x-oversampling enable. It synchronises the asynchronous serial line, validates the start bit at mid-bit, samples each data bit at bit centre, and presents the byte with a one-cycle `data_ready` strobe. A framing-error strobe is raised on a bad stop bit. It sits between the board RX pin and the host-side logic.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the `Serial_in` synchroniser (≥2).
- `clk`  input  1  system clock; single clock domain.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `RX_EN`  input  1  enables detection of new frames.
- `baud_x16_en`  input  1  one-`clk` pulse, 16 per bit period (shared baud generator).
- `Serial_in`  input  1  asynchronous serial line, idle high.
- `Rx_output`  output  8  last correctly framed byte.
- `RX_ACTIVE`  output  1  high while a frame is in progress.
- `data_ready`  output  1  one-`clk` pulse when a new byte is in `Rx_output`.
- `frame_error`  output  1  one-`clk` pulse on a stop bit sampled low.

## Operation
- Reset values: `Rx_output`=8'h00, `RX_ACTIVE`=0, `data_ready`=0, `frame_error`=0, state IDLE, synchroniser flops=1, counters=0.
- All state and counter updates occur only on `clk` edges where `baud_x16_en`=1. The exception is `data_ready`/`frame_error`, which clear on the next `clk` edge regardless of the enable.
- `rx_s` is `Serial_in` after `SYNC_STAGES` flops. All decisions use `rx_s`.
- IDLE: if `RX_EN`=1 and `rx_s`=0 on a tick, go to START, clear the counter, and set `RX_ACTIVE`=1. Call this tick 0.
- START: the counter increments each tick. On tick 8 (counter==7):
  - if `rx_s`=0, clear the counter, clear the bit index, and go to RECV;
  - otherwise it is a false start: go to IDLE with `RX_ACTIVE`=0.
- RECV: the counter counts 0..15. At counter==15, shift `rx_s` into the shift register at `bit_index` (LSB first), clear the counter, and increment the index. After bit 7 is taken, go to STOP.
  - Bit i is sampled on tick 8+16(i+1).
- STOP: at counter==15 (tick 152):
  - if `rx_s`=1: load `Rx_output` from the shift register, pulse `data_ready`, set `RX_ACTIVE`=0, go to IDLE;
  - if `rx_s`=0: `Rx_output` is unchanged, pulse `frame_error`, set `RX_ACTIVE`=0, go to BREAK.
- BREAK: remain until a tick with `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- `RX_EN` deasserted mid-frame has no effect; the current frame completes. It only gates the IDLE→START transition.
- Reset asserted mid-frame forces reset values immediately; no strobe is emitted.
- Illegal state encodings go to IDLE on the next tick.

## Timing
- Synchroniser latency: `SYNC_STAGES` `clk` cycles from `Serial_in` to `rx_s`.
- Frame latency: `data_ready` rises on the `clk` edge of tick 152, counted from the detection tick, and is high for exactly one `clk` cycle.
- `Rx_output` is valid on the same edge as `data_ready` and is held until the next good frame.
- Back-to-back frames: a start bit beginning immediately after the stop bit is accepted. IDLE is re-entered on tick 152 and can detect from tick 153 on.
- `data_ready` and `frame_error` are never high together.
- Start-edge detection uncertainty is ≤1 tick, so sampling lands within 1/16 bit of centre.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings IDLE/START/RECV/STOP/BREAK (3-bit), shared with the transmitter where the names overlap;
  - `OVERSAMPLE`=16, `DATA_BITS`=8, `MID_SAMPLE`=7.
- Sub-module `sync_ff` (parameterised depth, reset value 1) provides the synchroniser and is reusable for other asynchronous inputs.
- The remainder is a single FSM with a 4-bit tick counter, a 3-bit bit index and an 8-bit shift register.

## Test plan
- Byte 8'hA5 sent by the transmitter model at 16 ticks/bit → `data_ready` pulse at tick 152, `Rx_output`=8'hA5, `RX_ACTIVE` high for ticks 0–151, `frame_error`=0.
- Glitch: `Serial_in` low for 4 ticks then high → false start, back to IDLE, no strobe, `RX_ACTIVE` returns to 0 at tick 8.
- Stop bit forced low on byte 8'h3C → `frame_error` pulse, `Rx_output` keeps the previous value. Line held low for 40 ticks → no new frame until the line returns high.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap → three `data_ready` pulses with the correct bytes.
- `rst_n` pulsed low at bit 4 of 8'h81 → outputs return to reset values immediately. The next clean 8'h81 is received correctly.
- `RX_EN`=0 with a frame on the line → no reception. `RX_EN` dropped mid-frame → the frame still completes with `data_ready`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and framing constants shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RECV  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_SAMPLE = 7;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= {DEPTH{RST_VAL}};
        else        r_q <= {r_q[DEPTH-2:0], i_d};
    end
    assign o_q = r_q[DEPTH-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver on a shared 16x tick; validates start at mid-bit, samples bits at centre,
// strobes data_ready on a good stop bit and frame_error on a low one.
module uart_rx import uart_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX_EN,
    input  logic       baud_x16_en,
    input  logic       Serial_in,
    output logic [7:0] Rx_output,
    output logic       RX_ACTIVE,
    output logic       data_ready,
    output logic       frame_error
);
    localparam logic [3:0] MID      = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic       w_rx_s;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_out, w_out_nxt;
    logic       r_ready, w_ready_nxt;
    logic       r_ferr, w_ferr_nxt;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (Serial_in),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (baud_x16_en) begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_idx   <= w_idx_nxt;
                r_shift <= w_shift_nxt;
                r_out   <= w_out_nxt;
            end
            // strobes self-clear on the very next clk, tick or not
            r_ready <= baud_x16_en & w_ready_nxt;
            r_ferr  <= baud_x16_en & w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 4'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_out_nxt   = r_out;
        w_ready_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (RX_EN && !w_rx_s) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == MID) begin
                    w_state_nxt = w_rx_s ? IDLE : RECV;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            RECV: begin
                if (r_cnt == LAST) begin
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_cnt_nxt          = '0;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == LAST_BIT) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : BREAK;
                    w_ready_nxt = w_rx_s;
                    w_ferr_nxt  = !w_rx_s;
                    w_out_nxt   = w_rx_s ? r_shift : r_out;
                end
            end
            BREAK: begin
                // hold off until the line recovers so a stuck-low line cannot retrigger
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign Rx_output   = r_out;
    assign RX_ACTIVE   = (r_state == START) || (r_state == RECV) || (r_state == STOP);
    assign data_ready  = r_ready;
    assign frame_error = r_ferr;
endmodule
